// File: rtl/pfb_sched_pkg.sv
// Shared types, default parameters and the round-robin pick helper for the
// PFB output scheduling stages.
package pfb_sched_pkg;

   localparam int DEF_N_CH        = 4;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_FRAME_LEN   = 1024;
   localparam int DEF_STALL_LIMIT = 4096;

   // rr_pick works on a fixed-width vector so it can serve any channel count up to 32.
   localparam int RR_MAX_CH = 32;
   localparam int RR_ID_W   = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } sched_state_e;

   // Unused upper request bits are zero, so wrapping modulo 32 visits the
   // real channels in the same order as wrapping modulo the channel count.
   function automatic logic [RR_ID_W-1:0] rr_pick(input logic [RR_MAX_CH-1:0] valid,
                                                  input logic [RR_ID_W-1:0]   ptr);
      logic [RR_ID_W-1:0] idx;
      logic [RR_ID_W-1:0] pick;
      logic               hit;
      pick = ptr;
      hit  = 1'b0;
      for (int i = 0; i < RR_MAX_CH; i++) begin
         idx = ptr + RR_ID_W'(i);
         if (!hit && valid[idx]) begin
            pick = idx;
            hit  = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/pfb_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or above ptr,
// wrapping around; found flags that any channel is requesting.
module pfb_rr_arbiter
   import pfb_sched_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] valid,
   input  logic [CH_W-1:0] ptr,
   output logic [CH_W-1:0] pick,
   output logic            found
);

   logic [RR_MAX_CH-1:0] valid_ext;
   logic [RR_ID_W-1:0]   ptr_ext;

   always_comb begin
      valid_ext            = '0;
      valid_ext[N_CH-1:0]  = valid;
      ptr_ext              = '0;
      ptr_ext[CH_W-1:0]    = ptr;
      pick                 = CH_W'(rr_pick(valid_ext, ptr_ext));
      found                = |valid;
   end

endmodule

// File: rtl/pfb_output_scheduler.sv
// Frame-level round-robin merge of per-channel PFB output streams into one
// AXI-Stream, with channel tagging, frame-length checking and a stall watchdog.
module pfb_output_scheduler
   import pfb_sched_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int FRAME_LEN   = DEF_FRAME_LEN,
   parameter int STALL_LIMIT = DEF_STALL_LIMIT,
   parameter int CH_W        = $clog2(N_CH)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_CH*DATA_W-1:0]   s_tdata,
   input  logic [N_CH-1:0]          s_tvalid,
   input  logic [N_CH-1:0]          s_tlast,
   output logic [N_CH-1:0]          s_tready,
   output logic [DATA_W-1:0]        m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic [CH_W-1:0]          m_tuser,
   output logic                     len_err,
   output logic                     block
);

   localparam int CNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(FRAME_LEN - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
   localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(N_CH - 1);

   sched_state_e        state_q, state_d;
   logic [CH_W-1:0]     grant_q, grant_d;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
   logic                m_tvalid_q, m_tvalid_d;
   logic                m_tlast_q, m_tlast_d;
   logic [CH_W-1:0]     m_tuser_q, m_tuser_d;
   logic                len_err_q, len_err_d;
   logic                block_q, block_d;

   logic [CH_W-1:0]     arb_pick;
   logic                arb_found;
   logic [DATA_W-1:0]   grant_data;
   logic                grant_valid;
   logic                grant_last;
   logic                out_rdy;
   logic                accept;
   logic                at_last_beat;
   logic                frame_end;
   logic                out_hs;

   pfb_rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_arb (
      .valid (s_tvalid),
      .ptr   (rr_ptr_q),
      .pick  (arb_pick),
      .found (arb_found)
   );

   always_comb begin
      grant_data = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (grant_q == CH_W'(c)) grant_data = s_tdata[c*DATA_W +: DATA_W];
      end
   end

   // The output register can take a new beat whenever it is empty or draining this cycle.
   assign grant_valid  = s_tvalid[grant_q];
   assign grant_last   = s_tlast[grant_q];
   assign out_rdy      = ~m_tvalid_q | m_tready;
   assign accept       = (state_q == BURST) & grant_valid & out_rdy;
   assign at_last_beat = (beat_cnt_q == LAST_BEAT);
   assign frame_end    = accept & (grant_last | at_last_beat);
   assign out_hs       = m_tvalid_q & m_tready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d = BURST;
               grant_d = arb_pick;
            end
         end
         BURST: begin
            if (frame_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_tready = '0;
      if (state_q == BURST) s_tready[grant_q] = out_rdy;
   end

   always_comb begin
      m_tdata_d  = m_tdata_q;
      m_tuser_d  = m_tuser_q;
      m_tlast_d  = m_tlast_q;
      m_tvalid_d = m_tvalid_q;
      if (accept) begin
         m_tdata_d  = grant_data;
         m_tuser_d  = grant_q;
         m_tlast_d  = grant_last | at_last_beat;
         m_tvalid_d = 1'b1;
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end

      // A frame is well-formed only when tlast and the final count coincide.
      len_err_d = frame_end & (grant_last ^ at_last_beat);

      beat_cnt_d = beat_cnt_q;
      if (frame_end)   beat_cnt_d = '0;
      else if (accept) beat_cnt_d = beat_cnt_q + 1'b1;

      rr_ptr_d = rr_ptr_q;
      if (frame_end) rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;

      stall_cnt_d = stall_cnt_q;
      if (out_hs)                                                   stall_cnt_d = '0;
      else if (m_tvalid_q && !m_tready && stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + 1'b1;

      block_d = (stall_cnt_q == STALL_MAX);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_tdata_q   <= '0;
         m_tuser_q   <= '0;
         m_tlast_q   <= 1'b0;
         m_tvalid_q  <= 1'b0;
         len_err_q   <= 1'b0;
         beat_cnt_q  <= '0;
         rr_ptr_q    <= '0;
         stall_cnt_q <= '0;
         block_q     <= 1'b0;
      end else begin
         m_tdata_q   <= m_tdata_d;
         m_tuser_q   <= m_tuser_d;
         m_tlast_q   <= m_tlast_d;
         m_tvalid_q  <= m_tvalid_d;
         len_err_q   <= len_err_d;
         beat_cnt_q  <= beat_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         stall_cnt_q <= stall_cnt_d;
         block_q     <= block_d;
      end
   end

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign m_tuser  = m_tuser_q;
   assign len_err  = len_err_q;
   assign block    = block_q;

endmodule

// File: tb/tb_pfb_output_scheduler.sv
// Scoreboard bench for pfb_output_scheduler: per-channel source queues feed
// the DUT, accepted beats are predicted into a queue and matched on output.
module tb_pfb_output_scheduler;

   localparam int N_CH        = 4;
   localparam int DATA_W      = 32;
   localparam int FRAME_LEN   = 8;
   localparam int STALL_LIMIT = 16;
   localparam int CH_W        = 2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CH_W-1:0]   user;
      logic              last;
   } exp_t;

   logic                   clock = 1'b0;
   logic                   reset;
   wire  [N_CH*DATA_W-1:0] s_tdata;
   logic [DATA_W-1:0]      s_data_arr [N_CH];
   logic [N_CH-1:0]        s_tvalid;
   logic [N_CH-1:0]        s_tlast;
   logic [N_CH-1:0]        s_tready;
   logic [DATA_W-1:0]      m_tdata;
   logic                   m_tvalid;
   logic                   m_tready;
   logic                   m_tlast;
   logic [CH_W-1:0]        m_tuser;
   logic                   len_err;
   logic                   block;

   always #5 clock = ~clock;

   for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign s_tdata[g*DATA_W +: DATA_W] = s_data_arr[g];
   end

   pfb_output_scheduler #(
      .N_CH        (N_CH),
      .DATA_W      (DATA_W),
      .FRAME_LEN   (FRAME_LEN),
      .STALL_LIMIT (STALL_LIMIT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .m_tuser  (m_tuser),
      .len_err  (len_err),
      .block    (block)
   );

   logic [DATA_W:0]   src_q [N_CH][$];
   exp_t              sb[$];
   int                frame_log[$];
   int                gap_log[$];
   int                checks = 0;
   int                failures = 0;
   int                cyc = 0;
   int                seq = 0;
   int                out_cnt = 0;
   int                tlast_cnt = 0;
   int                err_seen = 0;
   int                acc_cnt = 0;
   int                mdl_cnt = 0;
   int                end_cyc = 0;
   bit                have_end = 0;
   logic [CH_W-1:0]   mdl_ch = '0;
   logic              exp_err = 1'b0;
   logic              prev_acc = 1'b0;
   logic              stalled = 1'b0;
   logic [DATA_W-1:0] last_push = '0;
   logic [DATA_W-1:0] held_data = '0;
   logic [CH_W-1:0]   held_user = '0;
   logic              held_last = 1'b0;

   task automatic refresh();
      logic [DATA_W:0] f;
      logic [CH_W-1:0] ci;
      for (int c = 0; c < N_CH; c++) begin
         ci = CH_W'(c);
         if (src_q[c].size() > 0) begin
            f             = src_q[c][0];
            s_tvalid[ci]  = 1'b1;
            s_tlast[ci]   = f[DATA_W];
            s_data_arr[c] = f[DATA_W-1:0];
         end else begin
            s_tvalid[ci]  = 1'b0;
            s_tlast[ci]   = 1'b0;
            s_data_arr[c] = '0;
         end
      end
   endtask

   task automatic push_frame(input int ch, input int n, input int last_at);
      for (int i = 1; i <= n; i++) begin
         seq++;
         src_q[ch].push_back({(i == last_at), 8'(ch), 24'(seq)});
      end
   endtask

   task automatic sb_clear();
      sb.delete();
      frame_log.delete();
      gap_log.delete();
      mdl_cnt  = 0;
      have_end = 0;
      exp_err  = 1'b0;
      prev_acc = 1'b0;
      stalled  = 1'b0;
   endtask

   function automatic bit src_empty();
      for (int c = 0; c < N_CH; c++) if (src_q[c].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: compare outputs against the scoreboard, predict accepted beats, advance sources.
   task automatic step(input logic rdy);
      logic [N_CH-1:0] hs;
      logic [CH_W-1:0] ci;
      logic [DATA_W:0] dummy;
      exp_t            e;
      logic            is_cnt_end;
      logic            want_last;
      m_tready = rdy;
      @(negedge clock);
      cyc++;
      if (prev_acc) begin
         checks++;
         if (m_tvalid !== 1'b1 || m_tdata !== last_push) begin
            failures++;
            $display("FAIL latency: m_tvalid=%0b m_tdata=%h required 1/%h", m_tvalid, m_tdata, last_push);
         end
      end
      checks++;
      if (len_err !== exp_err) begin
         failures++;
         $display("FAIL len_err: got %0b required %0b at cycle %0d", len_err, exp_err, cyc);
      end
      if (len_err === 1'b1) err_seen++;
      if (stalled && m_tvalid === 1'b1) begin
         checks++;
         if (m_tdata !== held_data || m_tuser !== held_user || m_tlast !== held_last) begin
            failures++;
            $display("FAIL stall_hold: got %h/%0d/%0b required %h/%0d/%0b",
                     m_tdata, m_tuser, m_tlast, held_data, held_user, held_last);
         end
      end
      checks++;
      if ($countones(s_tready) > 1) begin
         failures++;
         $display("FAIL tready_onehot: s_tready=%b required at most one bit", s_tready);
      end
      if (m_tvalid === 1'b1 && m_tready) begin
         out_cnt++;
         if (m_tlast === 1'b1) tlast_cnt++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_extra: got beat %h ch%0d with nothing expected", m_tdata, m_tuser);
         end else begin
            e = sb.pop_front();
            if (m_tdata !== e.data || m_tuser !== e.user || m_tlast !== e.last) begin
               failures++;
               $display("FAIL sb_beat: got %h/ch%0d/last%0b required %h/ch%0d/last%0b",
                        m_tdata, m_tuser, m_tlast, e.data, e.user, e.last);
            end
         end
      end
      stalled   = (m_tvalid === 1'b1) && !m_tready;
      held_data = m_tdata;
      held_user = m_tuser;
      held_last = m_tlast;
      hs        = s_tvalid & s_tready;
      prev_acc  = 1'b0;
      exp_err   = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         ci = CH_W'(c);
         if (hs[ci]) begin
            acc_cnt++;
            if (mdl_cnt == 0) begin
               frame_log.push_back(c);
               mdl_ch = ci;
               if (have_end) gap_log.push_back(cyc - end_cyc);
            end else begin
               checks++;
               if (ci !== mdl_ch) begin
                  failures++;
                  $display("FAIL grant_hold: accepted ch%0d mid-frame, required ch%0d", c, mdl_ch);
               end
            end
            is_cnt_end = (mdl_cnt == FRAME_LEN - 1);
            want_last  = s_tlast[ci] || is_cnt_end;
            exp_err    = want_last && (s_tlast[ci] != is_cnt_end);
            e.data     = s_data_arr[c];
            e.user     = ci;
            e.last     = want_last;
            sb.push_back(e);
            last_push  = e.data;
            prev_acc   = 1'b1;
            if (want_last) begin
               mdl_cnt  = 0;
               end_cyc  = cyc;
               have_end = 1;
            end else begin
               mdl_cnt++;
            end
         end
      end
      @(posedge clock);
      #1;
      for (int c = 0; c < N_CH; c++) begin
         ci = CH_W'(c);
         if (hs[ci]) dummy = src_q[c].pop_front();
      end
      refresh();
   endtask

   task automatic drain(input int budget, input logic [3:0] pat, output bit done);
      int i;
      i    = 0;
      done = 1'b0;
      while (!done && i < budget) begin
         if (src_empty() && sb.size() == 0 && m_tvalid === 1'b0) done = 1'b1;
         else begin
            step(pat[i % 4]);
            i++;
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      m_tready = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      for (int c = 0; c < N_CH; c++) s_data_arr[c] = '0;
      #3;
      checks++;
      if ({s_tready, m_tvalid, m_tlast, len_err, block, m_tdata, m_tuser} !== '0) begin
         failures++;
         $display("FAIL reset_async: tready=%b vld=%0b last=%0b err=%0b blk=%0b data=%h user=%0d required all 0",
                  s_tready, m_tvalid, m_tlast, len_err, block, m_tdata, m_tuser);
      end
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) step(1'b1);
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== '0 || block !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: vld=%0b tready=%b blk=%0b required 0/0000/0", m_tvalid, s_tready, block);
      end
   endtask

   task automatic test_round_robin();
      bit done;
      int base;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      sb_clear();
      base = out_cnt;
      push_frame(0, 8, 8);
      push_frame(0, 8, 8);
      push_frame(1, 8, 8);
      push_frame(2, 8, 8);
      push_frame(3, 8, 8);
      refresh();
      drain(300, 4'b1111, done);
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL rr_timeout: %0d beats left required 0", sb.size());
      end
      checks++;
      if (out_cnt - base != 40) begin
         failures++;
         $display("FAIL rr_count: got %0d beats required 40", out_cnt - base);
      end
      checks++;
      if (frame_log.size() != 5) begin
         failures++;
         $display("FAIL rr_frames: got %0d frames required 5", frame_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (frame_log[i] != exp_order[i]) begin
               failures++;
               $display("FAIL rr_order: frame %0d got ch%0d required ch%0d", i, frame_log[i], exp_order[i]);
            end
         end
      end
      checks++;
      if (gap_log.size() != 4) begin
         failures++;
         $display("FAIL rr_gaps: got %0d gaps required 4", gap_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (gap_log[i] != 2) begin
               failures++;
               $display("FAIL rr_bubble: gap %0d got %0d cycles required 2", i, gap_log[i]);
            end
         end
      end
   endtask

   task automatic test_full_frame();
      bit done;
      int base_out, base_last, base_err;
      sb_clear();
      base_out  = out_cnt;
      base_last = tlast_cnt;
      base_err  = err_seen;
      push_frame(2, 8, 8);
      refresh();
      drain(100, 4'b1111, done);
      checks++;
      if (!done || out_cnt - base_out != 8) begin
         failures++;
         $display("FAIL full_count: got %0d beats done=%0b required 8", out_cnt - base_out, done);
      end
      checks++;
      if (tlast_cnt - base_last != 1 || err_seen - base_err != 0) begin
         failures++;
         $display("FAIL full_flags: got tlast=%0d len_err=%0d required 1/0",
                  tlast_cnt - base_last, err_seen - base_err);
      end
      checks++;
      if (frame_log.size() != 1 || frame_log[0] != 2) begin
         failures++;
         $display("FAIL full_grant: got %0d frames first ch%0d required 1 frame ch2",
                  frame_log.size(), (frame_log.size() > 0) ? frame_log[0] : -1);
      end
   endtask

   task automatic test_backpressure();
      bit done;
      int base;
      sb_clear();
      base = out_cnt;
      push_frame(1, 8, 8);
      refresh();
      drain(200, 4'b1001, done);
      checks++;
      if (!done || out_cnt - base != 8 || sb.size() != 0) begin
         failures++;
         $display("FAIL bp_count: got %0d beats, %0d pending, done=%0b required 8/0/1",
                  out_cnt - base, sb.size(), done);
      end
   endtask

   task automatic test_length_errors();
      bit done;
      int base_last, base_err;
      sb_clear();
      base_last = tlast_cnt;
      base_err  = err_seen;
      push_frame(1, 5, 5);
      refresh();
      drain(100, 4'b1111, done);
      push_frame(0, 9, 9);
      refresh();
      drain(100, 4'b1111, done);
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL len_timeout: %0d beats left required 0", sb.size());
      end
      checks++;
      if (err_seen - base_err != 3) begin
         failures++;
         $display("FAIL len_pulses: got %0d len_err pulses required 3", err_seen - base_err);
      end
      checks++;
      if (tlast_cnt - base_last != 3) begin
         failures++;
         $display("FAIL len_tlast: got %0d m_tlast beats required 3", tlast_cnt - base_last);
      end
   endtask

   task automatic test_watchdog();
      bit done;
      int n;
      sb_clear();
      push_frame(3, 1, 1);
      refresh();
      n = 0;
      while (m_tvalid !== 1'b1 && n < 10) begin
         step(1'b0);
         n++;
      end
      checks++;
      if (m_tvalid !== 1'b1) begin
         failures++;
         $display("FAIL wd_load: m_tvalid=%0b required 1", m_tvalid);
      end
      for (int k = 1; k <= 17; k++) begin
         step(1'b0);
         checks++;
         if (block !== (k == 17)) begin
            failures++;
            $display("FAIL wd_rise: stall cycle %0d block=%0b required %0b", k, block, (k == 17));
         end
      end
      step(1'b0);
      checks++;
      if (block !== 1'b1) begin
         failures++;
         $display("FAIL wd_hold: block=%0b required 1", block);
      end
      step(1'b1);
      checks++;
      if (block !== 1'b1) begin
         failures++;
         $display("FAIL wd_release_edge: block=%0b required 1", block);
      end
      step(1'b0);
      checks++;
      if (block !== 1'b0) begin
         failures++;
         $display("FAIL wd_fall: block=%0b required 0", block);
      end
      drain(20, 4'b1111, done);
   endtask

   task automatic test_mid_reset();
      bit done;
      int base, n;
      sb_clear();
      push_frame(0, 2, 2);
      refresh();
      drain(50, 4'b1111, done);
      base = acc_cnt;
      push_frame(1, 8, 8);
      refresh();
      n = 0;
      while (acc_cnt - base < 3 && n < 20) begin
         step(1'b1);
         n++;
      end
      checks++;
      if (m_tvalid !== 1'b1 || m_tuser !== 2'd1) begin
         failures++;
         $display("FAIL mr_setup: vld=%0b user=%0d required 1/1", m_tvalid, m_tuser);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({s_tready, m_tvalid, m_tlast, len_err, block, m_tdata, m_tuser} !== '0) begin
         failures++;
         $display("FAIL mr_async: tready=%b vld=%0b last=%0b err=%0b blk=%0b data=%h user=%0d required all 0",
                  s_tready, m_tvalid, m_tlast, len_err, block, m_tdata, m_tuser);
      end
      for (int c = 0; c < N_CH; c++) src_q[c].delete();
      sb_clear();
      refresh();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      push_frame(0, 8, 8);
      push_frame(1, 2, 2);
      refresh();
      drain(100, 4'b1111, done);
      checks++;
      if (!done || frame_log.size() != 2) begin
         failures++;
         $display("FAIL mr_frames: got %0d frames done=%0b required 2/1", frame_log.size(), done);
      end else begin
         checks++;
         if (frame_log[0] != 0 || frame_log[1] != 1) begin
            failures++;
            $display("FAIL mr_order: got ch%0d,ch%0d required ch0,ch1", frame_log[0], frame_log[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_full_frame();
      test_backpressure();
      test_length_errors();
      test_watchdog();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: simulation time limit reached");
      $fatal(1, "simulation time limit reached");
   end

endmodule
